// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: accepts step/direction/speed commands, paces steps, then settles.
// Optional macro STEPPER_POS_TRACK_EN builds a wrapping signed step-position register.
module stepper_move_ctrl #(
  parameter int unsigned STEP_PERIOD_M0 = 600002,
  parameter int unsigned STEP_PERIOD_M1 = 600002,
  parameter int unsigned STEP_PERIOD_M2 = 600002,
  parameter int unsigned STEP_PERIOD_M3 = 600002,
  parameter int unsigned SETTLE_CYC     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_steps,
  input  logic [1:0]  cmd_mode,
  input  logic        stop,
  input  logic        limit,
  output logic        motor_en,
  output logic        motor_dir,
  output logic [1:0]  motor_mode,
  output logic        step_tick,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] pos
);

  localparam int unsigned PER_W  = 26;
  localparam int unsigned SET_W  = 20;
  localparam int unsigned STEP_W = 16;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [PER_W-1:0]    r_per_cnt;
  logic [SET_W-1:0]    r_set_cnt;
  logic [STEP_W-1:0]   r_steps_left;
  logic                r_dir;
  logic [MODE_W-1:0]   r_mode;
  logic                r_motor_en;
  logic                r_tick;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_cmd_ready;

  logic [PER_W-1:0]    w_period;
  logic                w_wrap;
  logic                w_accept;
  logic                w_tick_nx;
  logic                w_done_nx;
  logic                w_err_nx;

  // Step period of the latched speed mode
  always_comb begin
    w_period = PER_W'(STEP_PERIOD_M0);
    case (r_mode)
      2'd1:    w_period = PER_W'(STEP_PERIOD_M1);
      2'd2:    w_period = PER_W'(STEP_PERIOD_M2);
      2'd3:    w_period = PER_W'(STEP_PERIOD_M3);
      default: w_period = PER_W'(STEP_PERIOD_M0);
    endcase
  end

  assign w_wrap   = (r_per_cnt == (w_period - PER_W'(1)));
  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  // Next state; in RUN, stop beats limit abort beats step completion
  always_comb begin
    w_state_nx = r_state;
    w_tick_nx  = 1'b0;
    w_done_nx  = 1'b0;
    w_err_nx   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_err_nx   = 1'b0;
          w_state_nx = (cmd_steps == STEP_W'(0)) ? S_SETTLE : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nx = S_SETTLE;
        end else if (limit && r_dir) begin
          w_state_nx = S_SETTLE;
          w_err_nx   = 1'b1;
        end else if (w_wrap) begin
          w_tick_nx = 1'b1;
          if (r_steps_left == STEP_W'(1)) begin
            w_state_nx = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (r_set_cnt == SET_W'(SETTLE_CYC - 1)) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_per_cnt    <= '0;
      r_set_cnt    <= '0;
      r_steps_left <= '0;
      r_dir        <= 1'b0;
      r_mode       <= '0;
      r_motor_en   <= 1'b0;
      r_tick       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cmd_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_tick      <= w_tick_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_motor_en  <= (w_state_nx == S_RUN);
      r_busy      <= (w_state_nx != S_IDLE);
      r_cmd_ready <= (w_state_nx == S_IDLE);

      if (w_accept) begin
        r_dir        <= cmd_dir;
        r_mode       <= cmd_mode;
        r_steps_left <= cmd_steps;
      end else if (w_tick_nx) begin
        r_steps_left <= r_steps_left - STEP_W'(1);
      end

      // Period counter restarts on every step and on every RUN entry
      if ((r_state == S_RUN) && (w_state_nx == S_RUN) && !w_wrap) begin
        r_per_cnt <= r_per_cnt + PER_W'(1);
      end else begin
        r_per_cnt <= '0;
      end

      if ((r_state == S_SETTLE) && (w_state_nx == S_SETTLE)) begin
        r_set_cnt <= r_set_cnt + SET_W'(1);
      end else begin
        r_set_cnt <= '0;
      end
    end
  end

`ifdef STEPPER_POS_TRACK_EN
  logic [15:0] r_pos;

  // Position follows each emitted step and wraps modulo 2^16
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
    end else if (w_tick_nx) begin
      r_pos <= r_dir ? (r_pos - 16'd1) : (r_pos + 16'd1);
    end
  end

  assign pos = r_pos;
`else
  assign pos = '0;
`endif

  assign cmd_ready  = r_cmd_ready;
  assign motor_en   = r_motor_en;
  assign motor_dir  = r_dir;
  assign motor_mode = r_mode;
  assign step_tick  = r_tick;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl: directed and random moves against a timeline model of each move.
module tb_stepper_move_ctrl;

  localparam int unsigned P0 = 4;
  localparam int unsigned P1 = 5;
  localparam int unsigned P2 = 3;
  localparam int unsigned P3 = 2;
  localparam int unsigned SC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [1:0]  cmd_mode;
  logic        stop;
  logic        limit;
  logic        motor_en;
  logic        motor_dir;
  logic [1:0]  motor_mode;
  logic        step_tick;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] pos;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_pos = 16'd0;

  stepper_move_ctrl #(
    .STEP_PERIOD_M0(P0),
    .STEP_PERIOD_M1(P1),
    .STEP_PERIOD_M2(P2),
    .STEP_PERIOD_M3(P3),
    .SETTLE_CYC    (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_mode  (cmd_mode),
    .stop      (stop),
    .limit     (limit),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .motor_mode(motor_mode),
    .step_tick (step_tick),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  function automatic int period_of(input logic [1:0] m);
    case (m)
      2'd1:    return P1;
      2'd2:    return P2;
      2'd3:    return P3;
      default: return P0;
    endcase
  endfunction

  function automatic logic [15:0] pos_exp(input logic [15:0] p);
`ifdef STEPPER_POS_TRACK_EN
    return p;
`else
    return 16'd0 & p;
`endif
  endfunction

  // One move; kind 0 = none, 1 = stop, 2 = limit raised at sample abort_c (c = cycles after accept edge)
  task automatic do_move(input logic d, input int steps, input logic [1:0] m,
                         input int kind, input int abort_c, input bit hold);
    int p, nrun, fin, ticks;
    bit eff, lim_eff, exp_tick;
    logic [15:0] pexp;
    p       = period_of(m);
    nrun    = steps * p;
    eff     = ((kind == 1) || ((kind == 2) && d)) && (steps > 0) && (abort_c < nrun);
    lim_eff = eff && (kind == 2);
    fin     = eff ? abort_c + 1 : nrun;
    ticks   = 0;
    @(negedge clk);
    chk("ready_before_cmd", -1, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = 16'(steps);
    cmd_mode  = m;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    for (int c = 0; c <= fin + int'(SC); c++) begin
      exp_tick = (c > 0) && (c % p == 0) && (c / p <= steps) && (eff ? (c < fin) : (c <= fin));
      if (exp_tick) ticks++;
      pexp = d ? (m_pos - 16'(ticks)) : (m_pos + 16'(ticks));
      chk("step_tick", c, 32'(step_tick), 32'(exp_tick));
      chk("motor_en", c, 32'(motor_en), 32'(c < fin));
      chk("busy", c, 32'(busy), 32'(c < fin + int'(SC)));
      chk("done", c, 32'(done), 32'(c == fin + int'(SC)));
      chk("cmd_ready", c, 32'(cmd_ready), 32'(c >= fin + int'(SC)));
      chk("err", c, 32'(err), 32'(lim_eff && (c >= fin)));
      chk("motor_dir", c, 32'(motor_dir), 32'(d));
      chk("motor_mode", c, 32'(motor_mode), 32'(m));
      chk("pos", c, 32'(pos), 32'(pos_exp(pexp)));
      if ((kind == 1) && (c == abort_c)) stop = 1'b1;
      if ((kind == 2) && (c == abort_c)) limit = 1'b1;
      if (c < fin + int'(SC)) begin
        @(posedge clk);
        #1;
      end
    end
    cmd_valid = 1'b0;
    stop      = 1'b0;
    limit     = 1'b0;
    m_pos     = d ? (m_pos - 16'(ticks)) : (m_pos + 16'(ticks));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 0, 32'(cmd_ready), 32'd1);
    chk({tag, "_en"}, 0, 32'(motor_en), 32'd0);
    chk({tag, "_dir"}, 0, 32'(motor_dir), 32'd0);
    chk({tag, "_mode"}, 0, 32'(motor_mode), 32'd0);
    chk({tag, "_tick"}, 0, 32'(step_tick), 32'd0);
    chk({tag, "_busy"}, 0, 32'(busy), 32'd0);
    chk({tag, "_done"}, 0, 32'(done), 32'd0);
    chk({tag, "_err"}, 0, 32'(err), 32'd0);
    chk({tag, "_pos"}, 0, 32'(pos), 32'd0);
  endtask

  initial begin
    int steps, kind;
    logic [1:0] m;
    logic d;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = 16'd0;
    cmd_mode  = 2'd0;
    stop      = 1'b0;
    limit     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b0;

    // Reverse move aborted by limit after first tick
    do_move(1'b1, 5, 2'd0, 2, int'(P0), 1'b0);
    chk("limit_err", 0, 32'(err), 32'd1);
    chk("limit_pos", 0, 32'(pos), 32'(pos_exp(16'hFFFF)));
    // Three forward steps in mode 0 (err cleared by this accept)
    do_move(1'b0, 3, 2'd0, 0, 0, 1'b0);
    chk("err_cleared", 0, 32'(err), 32'd0);
    // Zero-step command, held valid
    do_move(1'b0, 0, 2'd1, 0, 0, 1'b1);
    // Stop after second tick, command held valid throughout
    do_move(1'b0, 10, 2'd0, 1, 2 * int'(P0), 1'b1);
    chk("stop_err", 0, 32'(err), 32'd0);
    // Stop on the cycle a wrap would fire: that tick is dropped
    do_move(1'b1, 4, 2'd2, 1, 3 * int'(P2) - 1, 1'b0);
    // Limit while moving forward is ignored
    do_move(1'b0, 3, 2'd3, 2, 1, 1'b0);
    chk("limit_fwd_err", 0, 32'(err), 32'd0);

    for (int i = 0; i < 14; i++) begin
      d     = 1'($urandom_range(0, 1));
      m     = 2'($urandom_range(0, 3));
      steps = int'($urandom_range(0, 6));
      kind  = int'($urandom_range(0, 2));
      do_move(d, steps, m, kind, int'($urandom_range(0, steps * period_of(m) + 2)),
              1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a move
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 16'd5;
    cmd_mode  = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_run");
    @(negedge clk);
    rst   = 1'b0;
    m_pos = 16'd0;
    for (int c = 1; c <= int'(SC) + 2; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_done", c, 32'(done), 32'd0);
      chk("post_rst_busy", c, 32'(busy), 32'd0);
    end

`ifdef STEPPER_POS_TRACK_EN
    // Walk up to 32767 and one beyond
    do_move(1'b0, 32768, 2'd3, 0, 0, 1'b0);
    chk("pos_wrap", 0, 32'(pos), 32'h0000_8000);
`else
    do_move(1'b0, 2, 2'd3, 0, 0, 1'b0);
    chk("pos_off", 0, 32'(pos), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
